// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the shared memory port.
//   slave  : seen by mem_port_arbiter (takes requests and mem_rdata, drives
//            responses, the memory strobe/address/data and the stall flags)
//   master : seen by the pipeline/memory side that drives the requests
// Signals:
//   if_req/if_addr/if_rdata/if_valid : fetch request and response
//   flush                            : PCSrcE, discard the fetch in flight
//   d_req/d_we/d_addr/d_wdata        : load/store request
//   d_rdata/d_valid                  : load data / store acknowledge
//   mem_en/mem_we/mem_addr/mem_wdata : single-port memory command
//   mem_rdata                        : memory read data (fixed latency)
//   stall_f/stall_m                  : hold signals for the hazard unit
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 17
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              flush;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_f;
  logic              stall_m;

  modport slave (
    input  if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );

  modport master (
    output if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data
// (load/store) stage. Each access runs IDLE -> ISSUE -> WAIT -> DONE; the
// owner gets a one-cycle valid pulse in DONE. Data has priority, but after
// MAX_D_STREAK consecutive data grants with a waiting fetch, fetch wins once.
// A flush while fetch owns the port lets the memory access finish but hides
// its result from the fetch side.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mem_port_arbiter_if.slave (requests, responses, memory command,
//           stall_f/stall_m)
module mem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 17,
  parameter int MEM_LAT      = 2,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STK_W = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [STK_W-1:0]  streak_q;
  logic              own_f_q;   // 1 = fetch owns the current access
  logic              drop_q;    // fetch result to be discarded
  logic              we_q;      // current access is a store
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic              grant_f, grant_d, capture;
  logic              if_valid_c, d_valid_c;

  // Saturating increment of the data-streak counter.
  function automatic logic [STK_W-1:0] sat_inc(input logic [STK_W-1:0] v);
    if (v >= STK_W'(MAX_D_STREAK)) return STK_W'(MAX_D_STREAK);
    else                           return v + STK_W'(1);
  endfunction

  // Arbitration, evaluated only in IDLE: data first unless the streak has
  // run out while fetch is waiting.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      grant_f = bus.if_req &&
                (!bus.d_req || (streak_q == STK_W'(MAX_D_STREAK)));
      grant_d = bus.d_req && !grant_f;
    end
  end

  // Last WAIT cycle: mem_rdata is valid for the access issued MEM_LAT ago.
  assign capture = (state_q == WAIT) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.if_req || bus.d_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; a flush arriving in DONE still hides that cycle's pulse.
  always_comb begin
    if_valid_c = (state_q == DONE) && own_f_q && !drop_q && !bus.flush;
    d_valid_c  = (state_q == DONE) && !own_f_q;
  end

  // Control: owner, latency counter, drop flag, streak
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      streak_q <= '0;
      own_f_q  <= 1'b0;
      drop_q   <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      if (grant_f || grant_d) begin
        own_f_q <= grant_f;
        we_q    <= grant_d && bus.d_we;
      end

      if (grant_f)
        streak_q <= '0;
      else if (grant_d)
        streak_q <= bus.if_req ? sat_inc(streak_q) : '0;

      if (state_q == ISSUE)
        cnt_q <= CNT_W'(MEM_LAT - 1);
      else if ((state_q == WAIT) && (cnt_q != '0))
        cnt_q <= cnt_q - CNT_W'(1);

      if (state_q == DONE)
        drop_q <= 1'b0;
      else if ((state_q != IDLE) && own_f_q && bus.flush)
        drop_q <= 1'b1;
    end
  end

  // Memory command: registered, one-cycle strobe during ISSUE
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (grant_f || grant_d) begin
      mem_en_q    <= 1'b1;
      mem_we_q    <= grant_d && bus.d_we;
      mem_addr_q  <= grant_f ? bus.if_addr : bus.d_addr;
      mem_wdata_q <= grant_d ? bus.d_wdata : '0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end
  end

  // Response capture; both read buses hold their value between accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (capture) begin
      if (own_f_q && !drop_q && !bus.flush)
        if_rdata_q <= bus.mem_rdata;
      else if (!own_f_q)
        d_rdata_q  <= we_q ? '0 : bus.mem_rdata;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_valid  = if_valid_c;
  assign bus.d_valid   = d_valid_c;
  assign bus.stall_f   = bus.if_req && !if_valid_c;
  assign bus.stall_m   = bus.d_req && !d_valid_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, MAX_D_STREAK=4).
// Cycle k of a scenario starts 1 time unit after a rising edge; inputs are
// set there and outputs are sampled on the following falling edge.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 17;

  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(2), .MAX_D_STREAK(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: fixed contents, read data appears two cycles after mem_en.
  function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
    case (a)
      12'h005: return 17'h1ABCD;
      12'h007: return 17'h13579;
      12'h009: return 17'h02468;
      12'h020: return 17'h0BEEF;
      12'h030: return 17'h0F00D;
      default: return 17'h00000;
    endcase
  endfunction

  logic [DATA_W-1:0] rd_p0, rd_p1;
  always @(posedge clk) begin
    rd_p0 <= bus.mem_en ? rom(bus.mem_addr) : '0;
    rd_p1 <= rd_p0;
  end
  assign bus.mem_rdata = rd_p1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.if_req = 1'b1;  // request held during reset must not be served
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      n_run++;
      if ({bus.mem_en, bus.mem_we, bus.if_valid, bus.d_valid} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_ctrl cyc=%0d got=%b exp=0000", c,
                 {bus.mem_en, bus.mem_we, bus.if_valid, bus.d_valid});
      end
      n_run++;
      if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== '0) begin
        n_fail++;
        $display("FAIL reset_data cyc=%0d addr=%h wdata=%h ifr=%h dr=%h exp all 0",
                 c, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata);
      end
    end
    bus.if_req = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    bus.if_req = 1'b1; bus.if_addr = 12'h005;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_run++;
      if ({bus.mem_en, bus.if_valid, bus.stall_f} !== {c == 1, c == 4, c < 4}) begin
        n_fail++;
        $display("FAIL fetch_ctrl cyc=%0d got en/vld/stall=%b exp=%b", c,
                 {bus.mem_en, bus.if_valid, bus.stall_f}, {c == 1, c == 4, c < 4});
      end
      if (c == 1) begin
        n_run++;
        if (bus.mem_addr !== 12'h005 || bus.mem_we !== 1'b0) begin
          n_fail++;
          $display("FAIL fetch_addr got addr=%h we=%b exp addr=005 we=0", bus.mem_addr, bus.mem_we);
        end
      end
      if (c == 4) begin
        n_run++;
        if (bus.if_rdata !== 17'h1ABCD) begin
          n_fail++;
          $display("FAIL fetch_rdata got=%h exp=1abcd", bus.if_rdata);
        end
      end
      step();
    end
    bus.if_req = 1'b0;
  endtask

  task automatic test_data_priority();
    bus.if_req = 1'b1; bus.if_addr = 12'h007;
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h020;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) bus.d_req = 1'b0;
      @(negedge clk);
      n_run++;
      if ({bus.mem_en, bus.d_valid, bus.if_valid, bus.stall_f, bus.stall_m} !==
          {(c == 1) || (c == 6), c == 4, c == 9, c < 9, c < 4}) begin
        n_fail++;
        $display("FAIL prio_ctrl cyc=%0d got en/dv/iv/sf/sm=%b exp=%b", c,
                 {bus.mem_en, bus.d_valid, bus.if_valid, bus.stall_f, bus.stall_m},
                 {(c == 1) || (c == 6), c == 4, c == 9, c < 9, c < 4});
      end
      if (c == 1 || c == 6) begin
        n_run++;
        if (bus.mem_addr !== ((c == 1) ? 12'h020 : 12'h007)) begin
          n_fail++;
          $display("FAIL prio_addr cyc=%0d got=%h exp=%h", c, bus.mem_addr,
                   (c == 1) ? 12'h020 : 12'h007);
        end
      end
      if (c == 4 || c == 9) begin
        n_run++;
        if (bus.d_rdata !== 17'h0BEEF) begin
          n_fail++;
          $display("FAIL prio_drdata cyc=%0d got=%h exp=0beef", c, bus.d_rdata);
        end
      end
      if (c == 9) begin
        n_run++;
        if (bus.if_rdata !== 17'h13579) begin
          n_fail++;
          $display("FAIL prio_irdata got=%h exp=13579", bus.if_rdata);
        end
      end
      step();
    end
    bus.if_req = 1'b0;
  endtask

  task automatic test_store();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'h010; bus.d_wdata = 17'h00042;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_run++;
      if ({bus.mem_en, bus.mem_we, bus.d_valid, bus.stall_m} !==
          {c == 1, c == 1, c == 4, c < 4}) begin
        n_fail++;
        $display("FAIL store_ctrl cyc=%0d got en/we/dv/sm=%b exp=%b", c,
                 {bus.mem_en, bus.mem_we, bus.d_valid, bus.stall_m},
                 {c == 1, c == 1, c == 4, c < 4});
      end
      if (c == 1) begin
        n_run++;
        if (bus.mem_wdata !== 17'h00042 || bus.mem_addr !== 12'h010) begin
          n_fail++;
          $display("FAIL store_cmd got addr=%h wdata=%h exp addr=010 wdata=00042",
                   bus.mem_addr, bus.mem_wdata);
        end
      end
      if (c == 4) begin
        n_run++;
        if (bus.d_rdata !== 17'h0) begin
          n_fail++;
          $display("FAIL store_rdata got=%h exp=0", bus.d_rdata);
        end
      end
      step();
    end
    bus.d_req = 1'b0; bus.d_we = 1'b0;
  endtask

  task automatic test_streak();
    int          grants;
    logic [6:0]  exp_f;
    grants = 0;
    exp_f  = 7'b0010000;  // grant #4 (0-based) goes to fetch
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h020;
    bus.if_req = 1'b1; bus.if_addr = 12'h007;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        if (grants < 7) begin
          n_run++;
          if ((bus.mem_addr == 12'h007) !== exp_f[grants]) begin
            n_fail++;
            $display("FAIL streak_owner grant=%0d got_fetch=%b exp_fetch=%b",
                     grants, bus.mem_addr == 12'h007, exp_f[grants]);
          end
        end
        grants++;
      end
      step();
    end
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    n_run++;
    if (grants != 7) begin
      n_fail++;
      $display("FAIL streak_count got=%0d exp=7", grants);
    end
  endtask

  task automatic test_flush();
    bus.if_req = 1'b1; bus.if_addr = 12'h009;
    for (int c = 0; c < 10; c++) begin
      bus.flush = (c == 2);
      if (c == 5) bus.if_addr = 12'h007;
      @(negedge clk);
      n_run++;
      if ({bus.mem_en, bus.if_valid, bus.stall_f} !==
          {(c == 1) || (c == 6), c == 9, c != 9}) begin
        n_fail++;
        $display("FAIL flush_ctrl cyc=%0d got en/iv/sf=%b exp=%b", c,
                 {bus.mem_en, bus.if_valid, bus.stall_f},
                 {(c == 1) || (c == 6), c == 9, c != 9});
      end
      if (c == 6) begin
        n_run++;
        if (bus.mem_addr !== 12'h007) begin
          n_fail++;
          $display("FAIL flush_refetch_addr got=%h exp=007", bus.mem_addr);
        end
      end
      if (c == 9) begin
        n_run++;
        if (bus.if_rdata !== 17'h13579) begin
          n_fail++;
          $display("FAIL flush_refetch_rdata got=%h exp=13579", bus.if_rdata);
        end
      end
      step();
    end
    bus.flush = 1'b0; bus.if_req = 1'b0;
  endtask

  task automatic test_flush_done_and_data();
    bus.if_req = 1'b1; bus.if_addr = 12'h005;
    for (int c = 0; c < 5; c++) begin
      bus.flush = (c == 4);
      @(negedge clk);
      if (c == 4) begin
        n_run++;
        if ({bus.if_valid, bus.stall_f} !== 2'b01) begin
          n_fail++;
          $display("FAIL flush_in_done got iv/sf=%b exp=01", {bus.if_valid, bus.stall_f});
        end
      end
      step();
    end
    bus.flush = 1'b0; bus.if_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h030;
    for (int c = 0; c < 5; c++) begin
      bus.flush = (c >= 1) && (c <= 4);
      @(negedge clk);
      n_run++;
      if (bus.d_valid !== (c == 4)) begin
        n_fail++;
        $display("FAIL flush_data_valid cyc=%0d got=%b exp=%b", c, bus.d_valid, c == 4);
      end
      if (c == 4) begin
        n_run++;
        if (bus.d_rdata !== 17'h0F00D) begin
          n_fail++;
          $display("FAIL flush_data_rdata got=%h exp=0f00d", bus.d_rdata);
        end
      end
      step();
    end
    bus.flush = 1'b0; bus.d_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.if_req = 1'b1; bus.if_addr = 12'h005;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) begin reset = 1'b1; bus.if_req = 1'b0; end
      if (c == 3) reset = 1'b0;
      @(negedge clk);
      if (c == 3) begin
        n_run++;
        if ({bus.mem_en, bus.mem_we, bus.if_valid, bus.d_valid, bus.stall_f, bus.stall_m,
             bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== '0) begin
          n_fail++;
          $display("FAIL rstmid_outputs en=%b we=%b addr=%h wdata=%h ifr=%h dr=%h exp all 0",
                   bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                   bus.if_rdata, bus.d_rdata);
        end
      end
      if (c >= 3) begin
        n_run++;
        if ({bus.mem_en, bus.if_valid, bus.d_valid} !== 3'b000) begin
          n_fail++;
          $display("FAIL rstmid_quiet cyc=%0d got en/iv/dv=%b exp=000", c,
                   {bus.mem_en, bus.if_valid, bus.d_valid});
        end
      end
      step();
    end
    bus.if_req = 1'b1; bus.if_addr = 12'h007;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_run++;
      if ({bus.mem_en, bus.if_valid} !== {c == 1, c == 4}) begin
        n_fail++;
        $display("FAIL rstmid_resume cyc=%0d got en/iv=%b exp=%b", c,
                 {bus.mem_en, bus.if_valid}, {c == 1, c == 4});
      end
      if (c == 4) begin
        n_run++;
        if (bus.if_rdata !== 17'h13579) begin
          n_fail++;
          $display("FAIL rstmid_rdata got=%h exp=13579", bus.if_rdata);
        end
      end
      step();
    end
    bus.if_req = 1'b0;
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    test_reset();
    test_fetch();
    test_data_priority();
    test_store();
    test_streak();
    test_flush();
    test_flush_done_and_data();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0t exp finish earlier", $time);
    $fatal(1);
  end

endmodule
